// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back path.
//   REG_ADDR_W / DATA_W / NUM_REGS : register file geometry (32 x 32)
//   wb_entry_t                     : one buffered write-back {rd, data}
//   arb_state_t                    : write arbiter FSM states
//   reg_bit()                      : one-hot mask for a register address
package rf_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

   // NORMAL: ALU has priority. FORCE: one cycle in which the MDU head is
   // drained regardless of ALU traffic (ALU is stalled by the pipeline).
   typedef enum logic {
      ARB_NORMAL = 1'b0,
      ARB_FORCE  = 1'b1
   } arb_state_t;

   function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] rd);
      logic [NUM_REGS-1:0] m;
      m     = '0;
      m[rd] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : enqueue when not full
//   pop/rdata  : dequeue when not empty; rdata is the current head (show-ahead)
//   full/empty : status from the registered occupancy count
//   count      : registered occupancy
// A push and a pop in the same cycle are both honoured; a push while full is
// dropped, so callers must gate push with !full.
module wb_fifo
   import rf_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  wb_entry_t              wdata,
   input  logic                   pop,
   output wb_entry_t              rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage needs no reset: occupancy is tracked by the pointers/count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Write-back arbiter in front of the register file's single write port.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data  : single-cycle ALU result, always accepted
//   mdu_valid/mdu_ready/mdu_rd/mdu_data : MDU result handshake into a buffer
//   issue_mdu/issue_rd         : MDU op issued; marks issue_rd busy
//   busy_mask                  : registers awaiting an MDU write-back
//   alu_stall                  : registered; ALU must be idle this cycle
//   RegWrite/RdAddr/RdData     : registered write port to the register file
// ALU wins by default; buffered MDU results drain on idle ALU cycles, and a
// starvation counter forces a one-cycle drain after STARVE_LIMIT ALU wins.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0]     alu_data,
   input  logic                  mdu_valid,
   output logic                  mdu_ready,
   input  logic [REG_ADDR_W-1:0] mdu_rd,
   input  logic [DATA_W-1:0]     mdu_data,
   input  logic                  issue_mdu,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   output logic [NUM_REGS-1:0]   busy_mask,
   output logic                  alu_stall,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] RdAddr,
   output logic [DATA_W-1:0]     RdData
);

   localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [NUM_REGS-1:0] R0_MASK = NUM_REGS'(1);

   arb_state_t            state;
   arb_state_t            state_nx;
   logic [CNT_W-1:0]      starve_cnt;
   logic [CNT_W-1:0]      starve_cnt_nx;

   wb_entry_t             push_entry;
   wb_entry_t             head;
   wb_entry_t             win;
   logic                  push;
   logic                  pop;
   logic                  sel_alu;
   logic                  win_valid;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [FCNT_W-1:0]     fifo_count;
   logic                  fifo_count_unused;

   logic [NUM_REGS-1:0]   set_mask;
   logic [NUM_REGS-1:0]   clr_mask;
   logic [NUM_REGS-1:0]   busy_nx;

   // ---------------------------------------------------------------------
   // MDU result buffer. Ready depends only on registered occupancy, so a
   // slot freed by a pop becomes visible the following cycle.
   // ---------------------------------------------------------------------
   assign mdu_ready     = !fifo_full;
   assign push          = mdu_valid && mdu_ready;
   assign push_entry.rd   = mdu_rd;
   assign push_entry.data = mdu_data;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_mdu_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (push_entry),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Occupancy is already summarised by full/empty for arbitration.
   assign fifo_count_unused = ^fifo_count;

   // ---------------------------------------------------------------------
   // Arbitration FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_NORMAL;
         starve_cnt <= '0;
      end else begin
         state      <= state_nx;
         starve_cnt <= starve_cnt_nx;
      end
   end

   // The counter only survives a cycle in which the ALU beat a non-empty
   // buffer; every pop, empty cycle or FORCE cycle returns it to zero.
   always_comb begin
      state_nx      = ARB_NORMAL;
      starve_cnt_nx = '0;
      pop           = 1'b0;
      sel_alu       = 1'b0;
      case (state)
         ARB_FORCE: begin
            // ALU is stalled by the pipeline here; the head goes out.
            pop = !fifo_empty;
         end
         default: begin
            if (alu_valid) begin
               sel_alu = 1'b1;
               if (!fifo_empty) begin
                  if (starve_cnt == CNT_W'(STARVE_LIMIT - 1))
                     state_nx = ARB_FORCE;
                  else
                     starve_cnt_nx = starve_cnt + 1'b1;
               end
            end else begin
               pop = !fifo_empty;
            end
         end
      endcase
   end

   assign alu_stall = (state == ARB_FORCE);
   assign win_valid = sel_alu || pop;

   always_comb begin
      if (sel_alu) begin
         win.rd   = alu_rd;
         win.data = alu_data;
      end else begin
         win = head;
      end
   end

   // ---------------------------------------------------------------------
   // Registered write port. Writes to r0 are consumed without a write
   // enable; address/data simply hold when idle.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWrite <= 1'b0;
         RdAddr   <= '0;
         RdData   <= '0;
      end else begin
         RegWrite <= win_valid && (win.rd != '0);
         if (win_valid) begin
            RdAddr <= win.rd;
            RdData <= win.data;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Scoreboard. Clearing on pop lands in the same register update as the
   // write port, so the bit drops in the cycle RegWrite shows the write.
   // Set is applied after clear so a same-cycle reissue keeps the bit.
   // ---------------------------------------------------------------------
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_mdu) set_mask = reg_bit(issue_rd);
      if (pop)       clr_mask = reg_bit(head.rd);
      busy_nx = ((busy_mask & ~clr_mask) | set_mask) & ~R0_MASK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_mask <= '0;
      else        busy_mask <= busy_nx;
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
   import rf_pkg::*;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        mdu_valid = 1'b0;
   logic        mdu_ready;
   logic [4:0]  mdu_rd = '0;
   logic [31:0] mdu_data = '0;
   logic        issue_mdu = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic [31:0] busy_mask;
   logic        alu_stall;
   logic        RegWrite;
   logic [4:0]  RdAddr;
   logic [31:0] RdData;

   always #5 clk = ~clk;

   rf_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
      .issue_mdu(issue_mdu), .issue_rd(issue_rd), .busy_mask(busy_mask),
      .alu_stall(alu_stall), .RegWrite(RegWrite), .RdAddr(RdAddr), .RdData(RdData)
   );

   // Protocol: the pipeline must not present an ALU result in a stall cycle.
   always @(posedge clk)
      if (rst_n) assert (!(alu_stall && alu_valid)) else $error("alu_valid during alu_stall");

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: a queue of pending MDU results, a count of ALU wins
   // since the head last moved, and the expected port values for next cycle.
   wb_entry_t   mq[$];
   bit [31:0]   m_busy;
   int          m_wins;
   bit          m_force;
   bit          m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   task automatic model_reset();
      mq.delete();
      m_busy = '0; m_wins = 0; m_force = 0;
      m_we = 0; m_addr = '0; m_data = '0;
   endtask

   task automatic model_step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                             input bit mv, input logic [4:0] mr, input logic [31:0] md,
                             input bit iv, input logic [4:0] ir);
      bit ready, win, popped;
      wb_entry_t w, e;
      ready = (mq.size() < DEPTH);
      win = 0; popped = 0; w = '0;
      if (m_force) begin
         w = mq.pop_front(); win = 1; popped = 1; m_force = 0; m_wins = 0;
      end else if (av) begin
         w.rd = ar; w.data = ad; win = 1;
         if (mq.size() > 0) begin
            m_wins++;
            if (m_wins == LIMIT) begin m_force = 1; m_wins = 0; end
         end else m_wins = 0;
      end else if (mq.size() > 0) begin
         w = mq.pop_front(); win = 1; popped = 1; m_wins = 0;
      end else m_wins = 0;
      if (popped) m_busy[w.rd] = 1'b0;
      if (iv && ir != 0) m_busy[ir] = 1'b1;
      if (mv && ready) begin e.rd = mr; e.data = md; mq.push_back(e); end
      m_we = win && (w.rd != 0);
      if (win) begin m_addr = w.rd; m_data = w.data; end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, mq.size() < DEPTH});
      chk("alu_stall", {31'd0, alu_stall}, {31'd0, m_force});
      chk("busy_mask", busy_mask, m_busy);
      chk("RegWrite", {31'd0, RegWrite}, {31'd0, m_we});
      if (m_we) begin
         chk("RdAddr", {27'd0, RdAddr}, {27'd0, m_addr});
         chk("RdData", RdData, m_data);
      end
   endtask

   // Called at a negedge: drive inputs, advance the model, check next cycle.
   task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit mv, input logic [4:0] mr, input logic [31:0] md,
                       input bit iv, input logic [4:0] ir);
      alu_valid = av; alu_rd = ar; alu_data = ad;
      mdu_valid = mv; mdu_rd = mr; mdu_data = md;
      issue_mdu = iv; issue_rd = ir;
      model_step(av, ar, ad, mv, mr, md, iv, ir);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      chk("rst RdAddr", {27'd0, RdAddr}, 32'd0);
      chk("rst RdData", RdData, 32'd0);
      rst_n = 1'b1;

      // ALU write latency
      step(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      chk("t1 RegWrite", {31'd0, RegWrite}, 32'd1);
      chk("t1 RdAddr", {27'd0, RdAddr}, 32'd3);
      chk("t1 RdData", RdData, 32'hDEADBEEF);

      // MDU write with scoreboard
      step(0, 0, 0, 0, 0, 0, 1, 5'd8);
      chk("t2 busy set", busy_mask, 32'h100);
      step(0, 0, 0, 1, 5'd8, 32'h12345678, 0, 0);
      chk("t2 busy hold", busy_mask, 32'h100);
      chk("t2 no write yet", {31'd0, RegWrite}, 32'd0);
      idle();
      chk("t2 RegWrite", {31'd0, RegWrite}, 32'd1);
      chk("t2 RdAddr", {27'd0, RdAddr}, 32'd8);
      chk("t2 RdData", RdData, 32'h12345678);
      chk("t2 busy clr", busy_mask, 32'h0);

      // Starvation: two MDU entries behind continuous ALU traffic
      step(1, 5'd10, 32'hA0, 1, 5'd4, 32'h44, 0, 0);
      step(1, 5'd11, 32'hA1, 1, 5'd5, 32'h55, 0, 0);
      chk("t3 ready full", {31'd0, mdu_ready}, 32'd0);
      step(1, 5'd12, 32'hA2, 0, 0, 0, 0, 0);
      step(1, 5'd13, 32'hA3, 0, 0, 0, 0, 0);
      chk("t3 no stall yet", {31'd0, alu_stall}, 32'd0);
      step(1, 5'd14, 32'hA4, 0, 0, 0, 0, 0);
      chk("t3 stall1", {31'd0, alu_stall}, 32'd1);
      idle();
      chk("t3 rd4 addr", {27'd0, RdAddr}, 32'd4);
      chk("t3 rd4 data", RdData, 32'h44);
      chk("t3 stall off", {31'd0, alu_stall}, 32'd0);
      for (int i = 0; i < 4; i++) step(1, 5'(15 + i), 32'hB0 + 32'(i), 0, 0, 0, 0, 0);
      chk("t3 stall2", {31'd0, alu_stall}, 32'd1);
      idle();
      chk("t3 rd5 addr", {27'd0, RdAddr}, 32'd5);
      chk("t3 rd5 data", RdData, 32'h55);

      // r0 writes are consumed silently
      step(0, 0, 0, 1, 5'd0, 32'hFFFF, 1, 5'd0);
      idle();
      chk("t4 RegWrite", {31'd0, RegWrite}, 32'd0);
      chk("t4 busy", busy_mask, 32'h0);

      // Same-cycle clear and set of r9: set wins
      step(0, 0, 0, 0, 0, 0, 1, 5'd9);
      step(0, 0, 0, 1, 5'd9, 32'h99, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 5'd9);
      chk("t5 RdAddr", {27'd0, RdAddr}, 32'd9);
      chk("t5 busy", busy_mask, 32'h200);
      step(0, 0, 0, 1, 5'd9, 32'h9A, 0, 0);
      idle();
      chk("t5 busy clr", busy_mask, 32'h0);

      // Randomised traffic
      for (int c = 0; c < 2000; c++) begin
         bit av, mv, iv;
         av = m_force ? 1'b0 : ($urandom_range(99) < 60);
         mv = ($urandom_range(99) < 40);
         iv = ($urandom_range(99) < 30);
         step(av, 5'($urandom), $urandom, mv, 5'($urandom), $urandom, iv, 5'($urandom));
      end

      // Mid-operation reset with two buffered entries and busy bits
      for (int i = 0; i < 10 && (mq.size() != 0 || m_force); i++) idle();
      step(1, 5'd20, 32'hC0C0C0C0, 1, 5'd12, 32'h1212, 1, 5'd12);
      step(1, 5'd21, 32'hC1C1C1C1, 1, 5'd13, 32'h1313, 1, 5'd13);
      chk("t6 ready full", {31'd0, mdu_ready}, 32'd0);
      chk("t6 busy", busy_mask & 32'h3000, 32'h3000);
      alu_valid = 0; mdu_valid = 0; issue_mdu = 0;
      rst_n = 1'b0;
      #1;
      chk("t6 rst RegWrite", {31'd0, RegWrite}, 32'd0);
      chk("t6 rst RdAddr", {27'd0, RdAddr}, 32'd0);
      chk("t6 rst RdData", RdData, 32'd0);
      chk("t6 rst busy", busy_mask, 32'd0);
      chk("t6 rst stall", {31'd0, alu_stall}, 32'd0);
      chk("t6 rst ready", {31'd0, mdu_ready}, 32'd1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) idle();
      chk("t6 no write", {31'd0, RegWrite}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-back arbiter on the producer side of the 32×32 register file's single write port. Merges single-cycle ALU results with out-of-order multi-cycle MDU (mul/div) results into one registered RegWrite/RdAddr/RdData stream. Keeps a scoreboard of registers awaiting an MDU result so the decode stage can stall on RAW hazards. Sits between the EX/MDU units and the register file. The file commits on the falling edge of the same cycle the arbiter drives the port.

## Interface
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive ALU-won cycles with a pending MDU entry before a forced drain
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle; always accepted
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  buffer can accept; transfer when mdu_valid && mdu_ready
- mdu_rd  in  5  MDU destination register
- mdu_data  in  32  MDU result
- issue_mdu  in  1  MDU op issued this cycle; reserve issue_rd
- issue_rd  in  5  destination of issued MDU op
- busy_mask  out  32  bit i = register i awaiting MDU write-back
- alu_stall  out  1  registered; pipeline must hold alu_valid low this cycle
- RegWrite  out  1  register-file write enable (registered)
- RdAddr  out  5  register-file write address (registered)
- RdData  out  32  register-file write data (registered)

## Operation
- Priority per cycle: ALU if alu_valid, else FIFO head if non-empty, else idle.
- MDU results are pushed into the FIFO on handshake. mdu_ready = !full, combinational from registered count.
- A push and a pop in the same cycle are legal when full. mdu_ready stays 0 that cycle; the freed slot is visible next cycle.
- Starvation counter:
  - Increments each cycle alu_valid wins while the FIFO is non-empty.
  - Clears on any FIFO pop or when the FIFO is empty.
  - On reaching STARVE_LIMIT, alu_stall = 1 for exactly one cycle and the counter clears.
  - In that cycle the FIFO head commits. alu_valid high there is a protocol violation; the bench asserts on it.
- Writes to rd = 0 are consumed (FIFO popped, counter behaves as a pop) but drive RegWrite = 0.
- Scoreboard:
  - issue_mdu with issue_rd ≠ 0 sets busy_mask[issue_rd].
  - Committing an MDU entry clears busy_mask[rd].
  - Set and clear on the same register in the same cycle: set wins.
  - busy_mask[0] is constantly 0.
  - ALU writes never touch the scoreboard.
- FSM: NORMAL → FORCE when the counter hits the limit. FORCE → NORMAL unconditionally after one cycle.

## Timing
- Reset values:
  - RegWrite = 0, RdAddr = 0, RdData = 0.
  - busy_mask = 0, alu_stall = 0, mdu_ready = 1.
  - FIFO empty, counter = 0, FSM = NORMAL.
- Reset asserted mid-operation discards buffered MDU results and all busy bits.
- Latency:
  - A winner selected in cycle N appears on RegWrite/RdAddr/RdData in cycle N+1 and is written on the negedge of N+1.
  - An MDU push in cycle N can commit no earlier than cycle N+1 (no FIFO bypass), i.e. it appears on the port in N+2.
- busy_mask bit clear is visible in the same cycle RegWrite for that MDU write is high.
- Throughput: one write per cycle. An MDU entry waits at most STARVE_LIMIT+1 cycles behind continuous ALU traffic once at head.

## Structure
- Shared package rf_pkg holds:
  - REG_ADDR_W = 5, DATA_W = 32, NUM_REGS = 32.
  - The wb_entry_t struct {rd, data}.
  - The arbiter FSM state enum.
- One sub-module, wb_fifo: parameterised synchronous FIFO with push/pop/full/empty/count and async active-low reset. The arbiter instantiates it for the MDU path.

## Test plan
- Reset, then alu_valid with rd = 3, data = 0xDEADBEEF → next cycle RegWrite = 1, RdAddr = 3, RdData = 0xDEADBEEF. All other outputs are at reset values before that.
- issue_mdu rd = 8, then MDU result rd = 8, data = 0x12345678 with no ALU traffic → busy_mask = 0x100 until the write cycle, then 0. Write appears 2 cycles after the handshake.
- Two MDU pushes (rd = 4, 5) with alu_valid held high → mdu_ready = 0 after the second push. alu_stall pulses after 4 ALU-won cycles, rd = 4 commits in the stall cycle, and rd = 5 commits 4 ALU cycles later.
- MDU write to rd = 0 plus issue_mdu rd = 0 → RegWrite stays 0, FIFO drains, busy_mask stays 0.
- Same-cycle commit of rd = 9 and issue_mdu rd = 9 → busy_mask[9] remains 1.
- Assert rst_n low with 2 buffered entries and busy bits set → all outputs return to reset values immediately. No write occurs after release.
